// File: rtl/noc_pkg.sv
// Shared NoC constants and the serializer FSM encoding used by the spike injection path.
package noc_pkg;
   localparam int PACKET_SIZE      = 32;
   localparam int FLIT_SIZE        = 4;
   localparam int FLITS_PER_PACKET = PACKET_SIZE / FLIT_SIZE;
   localparam int FLIT_CNT_WIDTH   = $clog2(FLITS_PER_PACKET);
   localparam int FIFO_DEPTH       = 4;
   localparam int PTR_WIDTH        = $clog2(FIFO_DEPTH);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } ser_state_e;
endpackage

// File: rtl/spike_packet_fifo.sv
// Packet queue for the spike serializer: circular storage, wrap-around pointers, registered full flag.
module spike_packet_fifo #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 4,
   parameter int PTR_WIDTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);
   logic [WIDTH-1:0]   mem_q [DEPTH];
   logic [PTR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_WIDTH:0]   count_q, count_d;
   logic                 full_q;
   logic                 push_ok, pop_ok;

   // A pop in the same cycle frees a slot, so a push at full still lands.
   assign push_ok = push_i && (!full_q || pop_i);
   assign pop_ok  = pop_i && (count_q != '0);
   assign count_d = count_q + {{PTR_WIDTH{1'b0}}, push_ok} - {{PTR_WIDTH{1'b0}}, pop_ok};

   assign data_o  = mem_q[rd_ptr_q];
   assign full_o  = full_q;
   assign empty_o = (count_q == '0);

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
         full_q  <= (count_d == (PTR_WIDTH+1)'(DEPTH));
      end
   end
endmodule

// File: rtl/spike_flit_serializer.sv
// Queues neuron spike packets and streams them MSB-flit first to the router local port.
// Define SPIKE_DROP_CNT_EN to expose a saturating counter of packets dropped at full.
module spike_flit_serializer #(
   parameter int PACKET_SIZE = 32,
   parameter int FLIT_SIZE   = 4,
   parameter int FIFO_DEPTH  = 4,
   parameter int PTR_WIDTH   = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [PACKET_SIZE-1:0] packet_in,
   input  logic                   write_en,
   output logic                   full,
   output logic [FLIT_SIZE-1:0]   flit_out,
   output logic                   write_req,
   input  logic                   router_full,
   output logic                   busy
`ifdef SPIKE_DROP_CNT_EN
   ,
   output logic [15:0]            drop_cnt
`endif
);
   import noc_pkg::*;

   localparam int FPP = PACKET_SIZE / FLIT_SIZE;
   localparam int CW  = (FPP > 1) ? $clog2(FPP) : 1;

   ser_state_e             state_q;
   logic [PACKET_SIZE-1:0] shreg_q;
   logic [CW-1:0]          flit_cnt_q;
   logic [FLIT_SIZE-1:0]   flit_out_q;
   logic                   write_req_q;

   logic [PACKET_SIZE-1:0] head;
   logic                   empty, pop, last_flit;

   assign last_flit = (flit_cnt_q == CW'(FPP-1));
   // Reload on the last flit's edge keeps back-to-back packets bubble-free.
   assign pop = !empty && ((state_q == IDLE) ||
                           (state_q == SEND && !router_full && last_flit));

   spike_packet_fifo #(
      .WIDTH     (PACKET_SIZE),
      .DEPTH     (FIFO_DEPTH),
      .PTR_WIDTH (PTR_WIDTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (write_en),
      .pop_i   (pop),
      .data_i  (packet_in),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         shreg_q     <= '0;
         flit_cnt_q  <= '0;
         flit_out_q  <= '0;
         write_req_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               write_req_q <= 1'b0;
               if (!empty) begin
                  shreg_q    <= head;
                  flit_cnt_q <= '0;
                  state_q    <= SEND;
               end
            end
            SEND: begin
               if (router_full) begin
                  write_req_q <= 1'b0;
               end else begin
                  flit_out_q  <= shreg_q[PACKET_SIZE-1 -: FLIT_SIZE];
                  write_req_q <= 1'b1;
                  shreg_q     <= shreg_q << FLIT_SIZE;
                  flit_cnt_q  <= flit_cnt_q + 1'b1;
                  if (last_flit) begin
                     if (!empty) begin
                        shreg_q    <= head;
                        flit_cnt_q <= '0;
                     end else begin
                        state_q <= IDLE;
                     end
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign flit_out  = flit_out_q;
   assign write_req = write_req_q;
   // The final flit is still on the wire the cycle after the FSM drops to IDLE.
   assign busy      = (state_q == SEND) || !empty || write_req_q;

`ifdef SPIKE_DROP_CNT_EN
   logic [15:0] drop_cnt_q;
   logic        drop;

   assign drop = write_en && full && !pop;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                              drop_cnt_q <= '0;
      else if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
   end

   assign drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_spike_flit_serializer.sv
// Directed bench for spike_flit_serializer: queue-level reference model plus literal checkpoints.
module tb_spike_flit_serializer;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] packet_in = '0;
   logic        write_en = 1'b0;
   logic        router_full = 1'b0;
   logic        full, write_req, busy;
   logic [3:0]  flit_out;
`ifdef SPIKE_DROP_CNT_EN
   logic [15:0] drop_cnt;
`endif

   int vecs = 0;
   int errs = 0;

   spike_flit_serializer dut (
      .clk         (clk),
      .reset       (reset),
      .packet_in   (packet_in),
      .write_en    (write_en),
      .full        (full),
      .flit_out    (flit_out),
      .write_req   (write_req),
      .router_full (router_full),
      .busy        (busy)
`ifdef SPIKE_DROP_CNT_EN
      ,
      .drop_cnt    (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: waiting packets in a queue, current packet with a count of flits left.
   logic [31:0] mq [$];
   logic [31:0] mcur;
   int          mleft;
   logic [3:0]  mflit;
   logic        mwr;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mq.delete();
         mcur = '0; mleft = 0; mflit = '0; mwr = 1'b0;
      end else begin
         bit emit, pop, acc;
         int qs;
         qs   = mq.size();
         emit = (mleft > 0) && !router_full;
         pop  = (qs > 0) && (mleft == 0 || (emit && mleft == 1));
         acc  = write_en && (qs < 4 || pop);
         mwr  = emit;
         if (emit) begin
            mflit = mcur[31:28];
            mcur  = mcur << 4;
            mleft--;
         end
         if (pop) begin
            mcur  = mq.pop_front();
            mleft = 8;
         end
         if (acc) mq.push_back(packet_in);
      end
   end

   always @(negedge clk) begin
      chk("m_write_req", write_req, mwr);
      chk("m_flit_out", flit_out, mflit);
      chk("m_full", full, mq.size() == 4);
      chk("m_busy", busy, (mleft > 0) || (mq.size() > 0) || mwr);
   end

   logic [31:0] pk [6];
   logic [31:0] w, got;
   logic [3:0]  cap [$];

   initial begin
      pk[0] = 32'h0123_4567; pk[1] = 32'h89AB_CDEF; pk[2] = 32'hFEDC_BA98;
      pk[3] = 32'h7654_3210; pk[4] = 32'h5A5A_C3C3; pk[5] = 32'h3C3C_A5A5;

      // reset state
      @(negedge clk); @(negedge clk);
      chk("rst_write_req", write_req, 0);
      chk("rst_flit_out", flit_out, 0);
      chk("rst_full", full, 0);
      chk("rst_busy", busy, 0);
      #2 reset = 1'b0;
      repeat (2) @(negedge clk);

      // single unthrottled packet
      w = 32'hA1B2C3D4;
      write_en = 1'b1; packet_in = w;
      @(negedge clk);
      write_en = 1'b0;
      chk("t1_busy0", busy, 1);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         chk("t1_wr", write_req, (k >= 2 && k <= 9));
         if (k >= 2 && k <= 9) chk("t1_flit", flit_out, (w >> (4*(9-k))) & 32'hF);
         if (k == 10) chk("t1_busy_low", busy, 0);
      end
      repeat (3) @(negedge clk);

      // router stall on edges 4..6
      w = 32'h12345678;
      write_en = 1'b1; packet_in = w;
      @(negedge clk);
      write_en = 1'b0;
      for (int k = 1; k <= 13; k++) begin
         @(negedge clk);
         chk("t3_wr", write_req, ((k >= 2 && k <= 3) || (k >= 7 && k <= 12)));
         if (k >= 2 && k <= 3)  chk("t3_flit", flit_out, k - 1);
         if (k >= 4 && k <= 6)  chk("t3_hold", flit_out, 2);
         if (k >= 7 && k <= 12) chk("t3_flit", flit_out, k - 4);
         router_full = (k >= 3 && k <= 5);
      end
      repeat (3) @(negedge clk);

      // fill the queue, drop at full, push accepted alongside a pop
      for (int k = 0; k <= 55; k++) begin
         write_en  = (k <= 5) || (k == 9);
         packet_in = (k < 5) ? pk[k] : (k == 5) ? 32'hDEADBEEF : pk[5];
         @(negedge clk);
         if (k == 3) chk("t2_full_early", full, 0);
         if (k == 4 || k == 5 || k == 9) chk("t2_full", full, 1);
         if (k >= 2 && k <= 50) chk("t2_wr_contig", write_req, (k <= 49));
         if (k == 50) chk("t2_busy_low", busy, 0);
         if (write_req) cap.push_back(flit_out);
      end
      write_en = 1'b0;
      chk("t2_flit_total", cap.size(), 48);
      for (int p = 0; p < 6; p++) begin
         got = '0;
         for (int f = 0; f < 8; f++)
            if (cap.size() > 0) got = {got[27:0], cap.pop_front()};
         chk("t2_pkt_order", got, pk[p]);
      end
`ifdef SPIKE_DROP_CNT_EN
      chk("t4_drop_cnt", drop_cnt, 1);
`endif
      repeat (3) @(negedge clk);

      // reset mid-packet with two packets queued
      for (int k = 0; k <= 4; k++) begin
         write_en  = (k <= 2);
         packet_in = pk[k];
         @(negedge clk);
      end
      write_en = 1'b0;
      chk("t6_wr_before", write_req, 1);
      chk("t6_flit3", flit_out, 2);
      #2 reset = 1'b1;
      #1;
      chk("t6_wr_async", write_req, 0);
      chk("t6_busy_async", busy, 0);
      chk("t6_full_async", full, 0);
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         chk("t6_no_flit", write_req, 0);
         chk("t6_idle", busy, 0);
      end
`ifdef SPIKE_DROP_CNT_EN
      chk("t6_drop_clr", drop_cnt, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
